// File: rtl/gpio_in_cond.sv
// gpio_in_cond: synchronise, debounce and edge-flag raw GPIO pins, with per-bit ack
// and a maskable interrupt request.
module gpio_in_cond #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic [WIDTH-1:0] ack_i,
    input  logic [WIDTH-1:0] irq_en_i,
    output logic             irq_o
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] r_s1, r_s2, r_stable, r_rise, r_fall;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] w_flip;
    // a bit flips only once its synchronised level has disagreed for the full window
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            w_flip[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == LAST);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= '0;
        end else begin
            r_s1     <= pins_i;
            r_s2     <= r_s1;
            r_stable <= r_stable ^ w_flip;
            r_rise   <= (w_flip & r_s2) | (r_rise & ~ack_i);
            r_fall   <= (w_flip & ~r_s2) | (r_fall & ~ack_i);
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= (r_s2[i] == r_stable[i] || w_flip[i]) ? '0 : r_cnt[i] + 1'b1;
        end
    end
    assign gpio_o = r_stable;
    assign rise_o = r_rise;
    assign fall_o = r_fall;
    assign irq_o  = |((r_rise | r_fall) & irq_en_i);
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: directed table-driven bench for gpio_in_cond (DEBOUNCE_CYCLES=16)
// plus a DEBOUNCE_CYCLES=1 instance for the minimum-latency case.
module tb_gpio_in_cond;
    logic       clk = 0;
    logic       reset_n = 0;
    logic [7:0] pins = 0, ack = 0, en = 0, pins1 = 0;
    logic [7:0] gpio, rise, fall, gpio1, rise1, fall1;
    logic       irq, irq1;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    gpio_in_cond #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .pins_i(pins), .gpio_o(gpio), .rise_o(rise),
        .fall_o(fall), .ack_i(ack), .irq_en_i(en), .irq_o(irq)
    );
    gpio_in_cond #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pins_i(pins1), .gpio_o(gpio1), .rise_o(rise1),
        .fall_o(fall1), .ack_i(8'h00), .irq_en_i(8'h00), .irq_o(irq1)
    );

    typedef struct {
        logic [7:0] pins, en, ack;
        int         cyc;
        logic [7:0] g, r, f;
        logic       irq;
    } vec_t;
    vec_t v [22];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        v[0]  = '{8'h00, 8'h00, 8'h00,  1, 8'h00, 8'h00, 8'h00, 1'b0};
        v[1]  = '{8'h01, 8'h00, 8'h00, 17, 8'h00, 8'h00, 8'h00, 1'b0};
        v[2]  = '{8'h01, 8'h00, 8'h00,  1, 8'h01, 8'h01, 8'h00, 1'b0};
        v[3]  = '{8'h01, 8'h01, 8'h00,  1, 8'h01, 8'h01, 8'h00, 1'b1};
        v[4]  = '{8'h01, 8'h01, 8'h01,  1, 8'h01, 8'h00, 8'h00, 1'b0};
        v[5]  = '{8'h09, 8'h01, 8'h00, 10, 8'h01, 8'h00, 8'h00, 1'b0};
        v[6]  = '{8'h01, 8'h01, 8'h00,  1, 8'h01, 8'h00, 8'h00, 1'b0};
        v[7]  = '{8'h09, 8'h01, 8'h00, 10, 8'h01, 8'h00, 8'h00, 1'b0};
        v[8]  = '{8'h01, 8'h01, 8'h00, 20, 8'h01, 8'h00, 8'h00, 1'b0};
        v[9]  = '{8'h09, 8'h01, 8'h00, 17, 8'h01, 8'h00, 8'h00, 1'b0};
        v[10] = '{8'h09, 8'h01, 8'h00,  1, 8'h09, 8'h08, 8'h00, 1'b0};
        v[11] = '{8'h09, 8'h01, 8'h08,  1, 8'h09, 8'h00, 8'h00, 1'b0};
        v[12] = '{8'h0D, 8'h04, 8'h00, 17, 8'h09, 8'h00, 8'h00, 1'b0};
        v[13] = '{8'h0D, 8'h04, 8'h00,  1, 8'h0D, 8'h04, 8'h00, 1'b1};
        v[14] = '{8'h09, 8'h04, 8'h00, 17, 8'h0D, 8'h04, 8'h00, 1'b1};
        v[15] = '{8'h09, 8'h04, 8'h04,  1, 8'h09, 8'h00, 8'h04, 1'b1};
        v[16] = '{8'h09, 8'h04, 8'h04,  1, 8'h09, 8'h00, 8'h00, 1'b0};
        v[17] = '{8'h2B, 8'h02, 8'h00, 17, 8'h09, 8'h00, 8'h00, 1'b0};
        v[18] = '{8'h2B, 8'h02, 8'h00,  1, 8'h2B, 8'h22, 8'h00, 1'b1};
        v[19] = '{8'h2B, 8'h02, 8'h02,  1, 8'h2B, 8'h20, 8'h00, 1'b0};
        v[20] = '{8'h2B, 8'h20, 8'h00,  1, 8'h2B, 8'h20, 8'h00, 1'b1};
        v[21] = '{8'h2B, 8'h00, 8'h20,  1, 8'h2B, 8'h00, 8'h00, 1'b0};

        en = 8'hFF;
        step(2);
        check("reset_gpio", 0, gpio, 8'h00);
        check("reset_irq", 0, {7'b0, irq}, 8'h00);
        en = 8'h00;
        reset_n = 1;

        for (int i = 0; i < 22; i++) begin
            pins = v[i].pins;
            en   = v[i].en;
            ack  = v[i].ack;
            step(v[i].cyc);
            check("gpio", i, gpio, v[i].g);
            check("rise", i, rise, v[i].r);
            check("fall", i, fall, v[i].f);
            check("irq", i, {7'b0, irq}, {7'b0, v[i].irq});
        end
        ack = 0;

        // reset mid-qualification: bit 7 rises, reset lands 10 edges in
        pins = 8'hAB;
        en   = 8'hFF;
        step(10);
        #2 reset_n = 0;
        #1;
        check("rst_async_gpio", 0, gpio, 8'h00);
        check("rst_async_rise", 0, rise, 8'h00);
        check("rst_async_fall", 0, fall, 8'h00);
        check("rst_async_irq", 0, {7'b0, irq}, 8'h00);
        @(posedge clk);
        #1 reset_n = 1;
        step(17);
        check("rst_requal_gpio", 17, gpio, 8'h00);
        step(1);
        check("rst_requal_gpio", 18, gpio, 8'hAB);
        check("rst_requal_rise", 18, rise, 8'hAB);
        check("rst_requal_irq", 18, {7'b0, irq}, 8'h01);

        pins1 = 8'hFF;
        step(2);
        check("min_gpio", 2, gpio1, 8'h00);
        step(1);
        check("min_gpio", 3, gpio1, 8'hFF);
        check("min_rise", 3, rise1, 8'hFF);
        pins1 = 8'h00;
        step(2);
        check("min_fall", 2, fall1, 8'h00);
        step(1);
        check("min_fall", 3, fall1, 8'hFF);
        check("min_rise_kept", 3, rise1, 8'hFF);
        check("min_gpio_low", 3, gpio1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
